// File: rtl/nes_pkg.sv
// Shared constants and types for the NES CPU bus controller: address map, DMA states, divider limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nes_pkg;

  // CPU address map upper bounds (inclusive)
  localparam logic [15:0] RAM_END = 16'h1FFF;
  localparam logic [15:0] PPU_END = 16'h3FFF;
  localparam logic [15:0] IO_END  = 16'h401F;

  // Clock divider: NTSC CPU cycle is ph 0..2; PAL stretches every fifth cycle to ph 0..3
  localparam logic [1:0] NTSC_LAST_PH = 2'd2;
  localparam logic [1:0] PAL_LONG_PH  = 2'd3;
  localparam logic [2:0] PAL_LONG_CYC = 3'd4;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_ALIGN,
    DMA_RD,
    DMA_WR
  } dma_state_e;

  typedef struct packed {
    logic ram;
    logic ppu;
    logic io;
    logic prg;
  } sel_t;

  // One-hot region decode of a CPU address
  function automatic sel_t addr_decode(input logic [15:0] a);
    sel_t s;
    s = '0;
    if (a <= RAM_END)      s.ram = 1'b1;
    else if (a <= PPU_END) s.ppu = 1'b1;
    else if (a <= IO_END)  s.io  = 1'b1;
    else                   s.prg = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/nes_phase_gen.sv
// CPU-cycle phase generator: divides the master clock into CPU cycles (NTSC 3 clk, PAL 16 clk / 5 cycles).
// Latency: strobes decode registered phase state combinationally, gated by enable.
// Backpressure: none; enable low freezes all state and silences every strobe.
module nes_phase_gen
  import nes_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic sys_type_i,
  output logic cpu_en_o,
  output logic cpu_preread_o,
  output logic cpu_xfer_o,
  output logic cyc_end_o,
  output logic parity_o
);

  logic [1:0] ph_q, ph_d;
  logic [2:0] pal_q, pal_d;
  logic       parity_q, parity_d;
  logic       mode_q, mode_d;   // video standard in force for the current CPU cycle
  logic       last_ph;

  // The long PAL cycle ends at ph 3; every other cycle ends at ph 2
  assign last_ph = (mode_q && (pal_q == PAL_LONG_CYC)) ? (ph_q == PAL_LONG_PH)
                                                       : (ph_q == NTSC_LAST_PH);

  assign cpu_en_o      = enable_i && (ph_q == 2'd0);
  assign cpu_preread_o = enable_i && (ph_q == 2'd1);
  assign cpu_xfer_o    = enable_i && (ph_q == 2'd2);
  assign cyc_end_o     = enable_i && last_ph;
  assign parity_o      = parity_q;

  // Next-state: advance phase, sample sys_type and toggle parity at the start of each CPU cycle
  always_comb begin
    ph_d     = ph_q;
    pal_d    = pal_q;
    parity_d = parity_q;
    mode_d   = mode_q;
    if (enable_i) begin
      if (ph_q == 2'd0) begin
        mode_d   = sys_type_i;
        parity_d = ~parity_q;
      end
      if (last_ph) begin
        ph_d  = 2'd0;
        pal_d = (mode_q && (pal_q != PAL_LONG_CYC)) ? pal_q + 3'd1 : 3'd0;
      end else begin
        ph_d = ph_q + 2'd1;
      end
    end
  end

  // Phase state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q     <= 2'd0;
      pal_q    <= 3'd0;
      parity_q <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      pal_q    <= pal_d;
      parity_q <= parity_d;
      mode_q   <= mode_d;
    end
  end

endmodule

// File: rtl/nes_bus_ctrl.sv
// NES CPU bus controller: CPU/OAM-DMA bus mux, address decode and OAM DMA engine stalling the CPU.
// Latency: bus passthrough and decode are combinational; DMA starts at the CPU cycle after the trigger write.
// Backpressure: cpu_rdy_o drops for the whole DMA (2*DMA_LEN+1 or +2 CPU cycles); enable low holds everything.
module nes_bus_ctrl
  import nes_pkg::*;
#(
  parameter int          DMA_LEN = 256,
  parameter logic [15:0] DMA_REG = 16'h4014,
  parameter logic [15:0] OAMDATA = 16'h2004
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        sys_type_i,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_r_i,
  input  logic [7:0]  cpu_wdata_i,
  input  logic [7:0]  bus_rdata_i,
  output logic        cpu_en_o,
  output logic        cpu_preread_o,
  output logic        cpu_xfer_o,
  output logic        cpu_rdy_o,
  output logic [15:0] bus_addr_o,
  output logic        bus_r_o,
  output logic        bus_w_o,
  output logic [7:0]  bus_wdata_o,
  output logic        sel_ram_o,
  output logic        sel_ppu_o,
  output logic        sel_io_o,
  output logic        sel_prg_o,
  output logic        dma_active_o
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  logic       cyc_end;
  logic       parity;
  dma_state_e state_q;
  logic [7:0] page_q, idx_q, data_q;
  logic       req_q;      // trigger seen at xfer, waiting for the cycle boundary (PAL long cycle)
  logic       extra_q;    // one more ALIGN cycle owed because the first one was odd
  logic       rdy_q, active_q;
  logic       trig;
  sel_t       sel;

  nes_phase_gen u_phase (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .sys_type_i    (sys_type_i),
    .cpu_en_o      (cpu_en_o),
    .cpu_preread_o (cpu_preread_o),
    .cpu_xfer_o    (cpu_xfer_o),
    .cyc_end_o     (cyc_end),
    .parity_o      (parity)
  );

  // Writes to the DMA register only count while idle, so a running DMA cannot be restarted
  assign trig = cpu_xfer_o && !cpu_r_i && (cpu_addr_i == DMA_REG) && (state_q == DMA_IDLE);

  // DMA FSM: state changes at CPU-cycle boundaries so each state owns whole CPU cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= DMA_IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
      req_q    <= 1'b0;
      extra_q  <= 1'b0;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
    end else begin
      if (trig) begin
        page_q <= cpu_wdata_i;
        req_q  <= 1'b1;
      end
      if (cpu_xfer_o && (state_q == DMA_RD)) data_q <= bus_rdata_i;
      if (cyc_end) begin
        case (state_q)
          DMA_IDLE: if (req_q || trig) begin
            state_q  <= DMA_ALIGN;
            extra_q  <= parity;   // parity already toggled: it is that of the upcoming ALIGN cycle
            req_q    <= 1'b0;
            rdy_q    <= 1'b0;
            active_q <= 1'b1;
          end
          DMA_ALIGN: begin
            if (extra_q) extra_q <= 1'b0;
            else         state_q <= DMA_RD;
          end
          DMA_RD: state_q <= DMA_WR;
          DMA_WR: begin
            idx_q <= idx_q + 8'd1;
            if (idx_q == LAST_IDX) begin
              idx_q    <= 8'h00;
              state_q  <= DMA_IDLE;
              rdy_q    <= 1'b1;
              active_q <= 1'b0;
            end else begin
              state_q <= DMA_RD;
            end
          end
          default: state_q <= DMA_IDLE;
        endcase
      end
    end
  end

  // Bus mux: CPU passthrough unless DMA owns the bus; reset drops DMA ownership at once
  always_comb begin
    bus_addr_o  = cpu_addr_i;
    bus_r_o     = cpu_r_i;
    bus_w_o     = ~cpu_r_i;
    bus_wdata_o = cpu_wdata_i;
    if (!rst_i) begin
      case (state_q)
        DMA_ALIGN: begin
          bus_r_o = 1'b0;
          bus_w_o = 1'b0;
        end
        DMA_RD: begin
          bus_addr_o = {page_q, idx_q};
          bus_r_o    = 1'b1;
          bus_w_o    = 1'b0;
        end
        DMA_WR: begin
          bus_addr_o  = OAMDATA;
          bus_r_o     = 1'b0;
          bus_w_o     = 1'b1;
          bus_wdata_o = data_q;
        end
        default: ;
      endcase
    end
  end

  assign sel          = addr_decode(bus_addr_o);
  assign sel_ram_o    = sel.ram;
  assign sel_ppu_o    = sel.ppu;
  assign sel_io_o     = sel.io;
  assign sel_prg_o    = sel.prg;
  assign cpu_rdy_o    = rdy_q;
  assign dma_active_o = active_q;

endmodule

// File: doc/nes_bus_ctrl.md
NES_BUS_CTRL -- requirements
Module: nes_bus_ctrl

Interface
REQ-001 Parameter DMA_LEN, default 256: bytes copied per OAM DMA.
REQ-002 Parameter DMA_REG, default 16'h4014: CPU address that triggers DMA.
REQ-003 Parameter OAMDATA, default 16'h2004: PPU register that DMA writes target.
REQ-004 clk  in  1: single system clock (PPU-rate master clock).
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 enable  in  1: global clock enable; when low, all state SHALL hold.
REQ-007 sys_type  in  1: 0 selects NTSC (3 clk per CPU cycle); 1 selects PAL (16 clk per 5 CPU cycles).
REQ-008 cpu_addr  in  16: CPU address. cpu_r  in  1: CPU read (1) or write (0). cpu_wdata  in  8: CPU write data.
REQ-009 bus_rdata  in  8: read data returned from the decoded target.
REQ-010 cpu_en, cpu_preread, cpu_xfer  out  1 each: per-CPU-cycle phase strobes.
REQ-011 cpu_rdy  out  1: low while DMA stalls the CPU.
REQ-012 bus_addr  out  16; bus_r, bus_w  out  1; bus_wdata  out  8: muxed bus from the CPU or DMA.
REQ-013 sel_ram, sel_ppu, sel_io, sel_prg  out  1 each: decode of bus_addr.
REQ-014 dma_active  out  1: DMA in progress.

Function
REQ-015 Phase counter ph SHALL count 0,1,2,0... in NTSC; cpu_en=(ph==0), cpu_preread=(ph==1), cpu_xfer=(ph==2), each gated by enable.
REQ-016 In PAL, a 0..4 cycle counter SHALL make every fifth CPU cycle four clocks long (ph 0..3); ph==3 asserts no strobe.
REQ-017 A change of sys_type SHALL take effect only at the next ph==0.
REQ-018 Decode: sel_ram for 0000-1FFF, sel_ppu for 2000-3FFF, sel_io for 4000-401F, sel_prg for >=4020; exactly one SHALL be high.
REQ-019 When idle, bus_addr/bus_r/bus_wdata SHALL pass the CPU signals through combinationally; bus_w=~cpu_r.
REQ-020 A CPU write to DMA_REG sampled at cpu_xfer SHALL latch page=cpu_wdata and enter ALIGN at the next cpu_en; cpu_rdy falls in the same clock.
REQ-021 DMA FSM states: IDLE, ALIGN, RD, WR. ALIGN lasts 1 CPU cycle, plus 1 more if the CPU cycle parity bit is odd; it then enters RD.
REQ-022 In RD the block SHALL drive bus_addr={page,idx}, bus_r=1, and latch bus_rdata at cpu_xfer.
REQ-023 In WR the block SHALL drive bus_addr=OAMDATA, bus_w=1, bus_wdata=the latched byte, then increment idx.
REQ-024 After the WR for idx=DMA_LEN-1, the FSM SHALL return to IDLE; cpu_rdy rises at that cpu_en. Total stall = 2*DMA_LEN+1 or 2*DMA_LEN+2 CPU cycles.
REQ-025 idx SHALL be 8 bits wide and wrap within the page; the page is never incremented.
REQ-026 A write to DMA_REG while dma_active SHALL be ignored.
REQ-027 The parity bit SHALL toggle on every cpu_en, including during DMA.

Reset
REQ-028 With rst high at a clk edge: ph=0, PAL counter=0, parity=0, FSM=IDLE, idx=0, page=0, latch=0.
REQ-029 In the cycle after reset, outputs SHALL be cpu_rdy=1, dma_active=0, cpu_en=1 if enable, and the bus in passthrough.
REQ-030 Reset during DMA SHALL abort it immediately with no further bus_w.

Structure
REQ-031 A shared package nes_pkg SHALL hold the address-map constants, DMA FSM state enum, and NTSC/PAL divider constants.
REQ-032 One sub-module, nes_phase_gen (ph, PAL counter, strobes, parity), SHALL be instantiated; the DMA FSM and decode stay in nes_bus_ctrl.

Verification
REQ-033 NTSC, enable=1 for 30 clk -> exactly 10 cpu_en pulses, each followed by preread then xfer on the next clocks.
REQ-034 PAL, 80 clk -> exactly 25 cpu_en pulses; every fifth interval is 4 clk.
REQ-035 Write 8'h02 to 4014 on an even cycle, memory 0200-02FF = i -> 256 writes to 2004 carrying data 0..255 in order; cpu_rdy low for 513 CPU cycles.
REQ-036 Same test started on an odd parity -> stall of 514 CPU cycles; data identical.
REQ-037 Assert rst at DMA idx=100 -> next clock has dma_active=0, cpu_rdy=1, and no further write to 2004.
REQ-038 Sweep cpu_addr over 1FFF, 2000, 3FFF, 4000, 401F, 4020, FFFF -> sel_ram, ppu, ppu, io, io, prg, prg respectively, one-hot.
